height_scan_ctrl: RTL and testbench

- Sequencer for the four-sensor height datapath of the baggage-drop unit.
- Scans the four height sensors one at a time over a shared 8-bit muxed input and computes the rounded pair-average height.
- Repeats scans until the result is stable, then hands the height to the drop logic through a valid/ready handshake.

---
 rtl/height_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_height_scan_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/height_scan_ctrl.sv
// height_scan_ctrl: sequencer for the four-sensor height datapath.
// Scans sensors 1..4 over one shared 8-bit mux and forms the rounded
// pair-average height. Scans repeat until STABLE_COUNT consecutive results
// agree within TOL, or until MAX_SCANS forces an unstable report. The
// result is handed over through a valid/ready handshake.
// Optional build macro: AUTO_RESCAN_EN (continuous measurement after the
// first start).
module height_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int STABLE_COUNT  = 3,
    parameter int TOL           = 1,
    parameter int MAX_SCANS     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [1:0] sens_sel,
    input  logic [7:0] sens_data,
    output logic       busy,
    output logic [7:0] height,
    output logic       height_valid,
    input  logic       height_ready,
    output logic       unstable
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int MW = $clog2(STABLE_COUNT + 1);
    localparam int CW = $clog2(MAX_SCANS + 1);

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [MW-1:0] STABLE_V    = MW'(STABLE_COUNT);
    localparam logic [CW-1:0] MAX_V       = CW'(MAX_SCANS);
    localparam logic [7:0]    TOL_V       = 8'(TOL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    logic [1:0]      sel_r;
    logic [SW-1:0]   settle_r;
    logic [7:0]      samp_r [4];
    logic [7:0]      prev_r;
    logic [MW-1:0]   match_r;
    logic [CW-1:0]   scan_r;
    logic [7:0]      height_r;
    logic            valid_r;
    logic            unstable_r;
    logic            busy_r;

    logic            pair_a_ok_s;
    logic            pair_b_ok_s;
    logic [9:0]      sum4_s;
    logic [8:0]      sum_a_s;
    logic [8:0]      sum_b_s;
    logic [7:0]      cand_s;
    logic [7:0]      diff_s;
    logic [MW-1:0]   match_next_s;
    logic [CW-1:0]   scan_next_s;

    assign sens_sel     = sel_r;
    assign busy         = busy_r;
    assign height       = height_r;
    assign height_valid = valid_r;
    assign unstable     = unstable_r;

    // Candidate height from the captured samples and the resulting match count.
    // A pair (s1,s3) or (s2,s4) with a zero reading is treated as a dead sensor.
    always_comb begin
        pair_a_ok_s  = (samp_r[0] != 8'd0) && (samp_r[2] != 8'd0);
        pair_b_ok_s  = (samp_r[1] != 8'd0) && (samp_r[3] != 8'd0);
        sum4_s       = {2'b00, samp_r[0]} + {2'b00, samp_r[1]}
                     + {2'b00, samp_r[2]} + {2'b00, samp_r[3]} + 10'd2;
        sum_a_s      = {1'b0, samp_r[0]} + {1'b0, samp_r[2]} + 9'd1;
        sum_b_s      = {1'b0, samp_r[1]} + {1'b0, samp_r[3]} + 9'd1;
        cand_s       = 8'd0;
        diff_s       = 8'd0;
        match_next_s = MW'(1);
        scan_next_s  = scan_r + CW'(1);

        if (pair_a_ok_s && pair_b_ok_s) begin
            cand_s = sum4_s[9:2];
        end else if (pair_a_ok_s) begin
            cand_s = sum_a_s[8:1];
        end else if (pair_b_ok_s) begin
            cand_s = sum_b_s[8:1];
        end else begin
            cand_s = 8'd0;
        end

        if (cand_s >= prev_r) begin
            diff_s = cand_s - prev_r;
        end else begin
            diff_s = prev_r - cand_s;
        end

        // The first scan of a measurement has nothing to compare against.
        if (scan_r == {CW{1'b0}}) begin
            match_next_s = MW'(1);
        end else if (diff_s <= TOL_V) begin
            match_next_s = match_r + MW'(1);
        end else begin
            match_next_s = MW'(1);
        end
    end

    // Measurement FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sel_r      <= 2'd0;
            settle_r   <= {SW{1'b0}};
            for (int i = 0; i < 4; i++) begin
                samp_r[i] <= 8'd0;
            end
            prev_r     <= 8'd0;
            match_r    <= {MW{1'b0}};
            scan_r     <= {CW{1'b0}};
            height_r   <= 8'd0;
            valid_r    <= 1'b0;
            unstable_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r  <= ST_SCAN;
                        sel_r    <= 2'd0;
                        settle_r <= {SW{1'b0}};
                        scan_r   <= {CW{1'b0}};
                        match_r  <= {MW{1'b0}};
                        busy_r   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // Sample on the last cycle of the settle window.
                    if (settle_r == SETTLE_LAST) begin
                        samp_r[sel_r] <= sens_data;
                        settle_r      <= {SW{1'b0}};
                        if (sel_r == 2'd3) begin
                            state_r <= ST_CALC;
                        end else begin
                            sel_r <= sel_r + 2'd1;
                        end
                    end else begin
                        settle_r <= settle_r + SW'(1);
                    end
                end
                ST_CALC: begin
                    prev_r  <= cand_s;
                    match_r <= match_next_s;
                    scan_r  <= scan_next_s;
                    // Stability takes precedence over the scan limit.
                    if (match_next_s == STABLE_V) begin
                        state_r    <= ST_DONE;
                        height_r   <= cand_s;
                        unstable_r <= 1'b0;
                        valid_r    <= 1'b1;
                    end else if (scan_next_s == MAX_V) begin
                        state_r    <= ST_DONE;
                        height_r   <= cand_s;
                        unstable_r <= 1'b1;
                        valid_r    <= 1'b1;
                    end else begin
                        state_r  <= ST_SCAN;
                        sel_r    <= 2'd0;
                        settle_r <= {SW{1'b0}};
                    end
                end
                ST_DONE: begin
                    if (valid_r && height_ready) begin
                        valid_r <= 1'b0;
`ifdef AUTO_RESCAN_EN
                        state_r  <= ST_SCAN;
                        sel_r    <= 2'd0;
                        settle_r <= {SW{1'b0}};
                        scan_r   <= {CW{1'b0}};
                        match_r  <= {MW{1'b0}};
`else
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_height_scan_ctrl.sv
// Directed testbench for height_scan_ctrl (default parameters).
module tb_height_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sens_sel;
    logic [7:0] sens_data;
    logic       busy;
    logic [7:0] height;
    logic       height_valid;
    logic       height_ready;
    logic       unstable;

    logic [7:0] sensors [4];
    int         checks;
    int         failures;

    height_scan_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sens_sel     (sens_sel),
        .sens_data    (sens_data),
        .busy         (busy),
        .height       (height),
        .height_valid (height_valid),
        .height_ready (height_ready),
        .unstable     (unstable)
    );

    // Sensor mux model: the selected sensor drives the shared input.
    assign sens_data = sensors[sens_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_sensors(input logic [7:0] a, input logic [7:0] b,
                               input logic [7:0] c, input logic [7:0] d);
        sensors[0] = a;
        sensors[1] = b;
        sensors[2] = c;
        sensors[3] = d;
    endtask

    // Pulse start for one edge; returns #1 after that edge.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until height_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (height_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sens_sel, height, height_valid, unstable, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state got sel=%0d h=%0d v=%0b u=%0b b=%0b want all 0",
                     sens_sel, height, height_valid, unstable, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        height_ready = 1'b1;
        set_sensors(8'd100, 8'd102, 8'd101, 8'd103);
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got %0b want 1", busy);
        end
        wait_valid(lat);
        checks++;
        if (lat != 27) begin
            failures++;
            $display("FAIL basic_latency got %0d want 27", lat);
        end
        checks++;
        if (height !== 8'd102 || unstable !== 1'b0) begin
            failures++;
            $display("FAIL basic_height got h=%0d u=%0b want h=102 u=0", height, unstable);
        end
        @(posedge clk);
        #1;
        checks++;
        if (height_valid !== 1'b0 || busy !== 1'b0 || height !== 8'd102) begin
            failures++;
            $display("FAIL basic_one_cycle got v=%0b b=%0b h=%0d want v=0 b=0 h=102",
                     height_valid, busy, height);
        end
    endtask

    task automatic test_pairs();
        logic [7:0] vec [4][5];
        int lat;
        // s1, s2, s3, s4, expected height
        vec[0] = '{8'd0,   8'd51,  8'd70,  8'd60,  8'd56};
        vec[1] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
        vec[2] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
        vec[3] = '{8'd1,   8'd2,   8'd2,   8'd2,   8'd2};
        height_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_sensors(vec[k][0], vec[k][1], vec[k][2], vec[k][3]);
            pulse_start();
            wait_valid(lat);
            checks++;
            if (lat != 27 || height !== vec[k][4] || unstable !== 1'b0) begin
                failures++;
                $display("FAIL pairs_%0d got lat=%0d h=%0d u=%0b want lat=27 h=%0d u=0",
                         k, lat, height, unstable, vec[k][4]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_unstable();
        logic [7:0] v;
        int lat;
        // Results alternate 100,110,...; never two in tolerance.
        height_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 8; k++) begin
            v = (k % 2 == 0) ? 8'd100 : 8'd110;
            set_sensors(v, v, v, v);
            repeat (9) @(posedge clk);
            #1;
            if (k == 6) begin
                checks++;
                if (height_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL unstable_early got v=%0b want 0 after 7 scans", height_valid);
                end
            end
        end
        checks++;
        if (height_valid !== 1'b1 || height !== 8'd110 || unstable !== 1'b1) begin
            failures++;
            $display("FAIL unstable_max got v=%0b h=%0d u=%0b want v=1 h=110 u=1",
                     height_valid, height, unstable);
        end
        height_ready = 1'b1;
        @(posedge clk);
        #1;
        // Results 100,101,100 are all within tolerance of their predecessor.
        height_ready = 1'b0;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            v = (k == 1) ? 8'd101 : 8'd100;
            set_sensors(v, v, v, v);
            repeat (9) @(posedge clk);
            #1;
        end
        checks++;
        if (height_valid !== 1'b1 || height !== 8'd100 || unstable !== 1'b0) begin
            failures++;
            $display("FAIL tol_stable got v=%0b h=%0d u=%0b want v=1 h=100 u=0",
                     height_valid, height, unstable);
        end
        height_ready = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
    endtask

    task automatic test_hold();
        int lat;
        int bad;
        height_ready = 1'b0;
        set_sensors(8'd50, 8'd50, 8'd50, 8'd50);
        pulse_start();
        wait_valid(lat);
        checks++;
        if (lat != 27 || height !== 8'd50) begin
            failures++;
            $display("FAIL hold_first got lat=%0d h=%0d want lat=27 h=50", lat, height);
        end
        for (int i = 0; i < 10; i++) begin
            start = (i == 3) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if (height_valid !== 1'b1 || height !== 8'd50 || unstable !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle_%0d got v=%0b h=%0d u=%0b b=%0b want v=1 h=50 u=0 b=1",
                         i, height_valid, height, unstable, busy);
            end
        end
        start = 1'b0;
        height_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (height_valid !== 1'b0 || busy !== 1'b0 || height !== 8'd50) begin
            failures++;
            $display("FAIL hold_accept got v=%0b b=%0b h=%0d want v=0 b=0 h=50",
                     height_valid, busy, height);
        end
`ifndef AUTO_RESCAN_EN
        // Back in IDLE: the start pulse seen in DONE must not have queued anything.
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (height_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL hold_idle got %0d active cycles want 0", bad);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int lat;
        height_ready = 1'b1;
        set_sensors(8'd80, 8'd80, 8'd80, 8'd80);
        pulse_start();
        repeat (13) @(posedge clk);
        #1;
        checks++;
        if (sens_sel !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mreset_pos got sel=%0d b=%0b want sel=2 b=1", sens_sel, busy);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({sens_sel, height, height_valid, unstable, busy} !== 13'd0) begin
            failures++;
            $display("FAIL mreset_state got sel=%0d h=%0d v=%0b u=%0b b=%0b want all 0",
                     sens_sel, height, height_valid, unstable, busy);
        end
        pulse_start();
        wait_valid(lat);
        checks++;
        if (lat != 27 || height !== 8'd80 || unstable !== 1'b0) begin
            failures++;
            $display("FAIL mreset_rerun got lat=%0d h=%0d u=%0b want lat=27 h=80 u=0",
                     lat, height, unstable);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        height_ready = 1'b1;
        set_sensors(8'd20, 8'd22, 8'd0, 8'd20);
        pulse_start();
        wait_valid(lat);
        checks++;
        if (lat != 27 || height !== 8'd21) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d h=%0d want lat=27 h=21", lat, height);
        end
        @(posedge clk);
        #1;
        set_sensors(8'd9, 8'd0, 8'd10, 8'd7);
        pulse_start();
        wait_valid(lat);
        checks++;
        if (lat != 27 || height !== 8'd10) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d h=%0d want lat=27 h=10", lat, height);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef AUTO_RESCAN_EN
    task automatic test_auto_rescan();
        int lat;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        height_ready = 1'b1;
        set_sensors(8'd40, 8'd40, 8'd40, 8'd40);
        pulse_start();
        wait_valid(lat);
        checks++;
        if (lat != 27 || height !== 8'd40) begin
            failures++;
            $display("FAIL auto_first got lat=%0d h=%0d want lat=27 h=40", lat, height);
        end
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            checks++;
            if (height_valid !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL auto_accept_%0d got v=%0b b=%0b want v=0 b=1", r, height_valid, busy);
            end
            // Counted from the acceptance edge, which re-enters SCAN.
            wait_valid(lat);
            checks++;
            if (lat != 27 || height !== 8'd40 || busy !== 1'b1) begin
                failures++;
                $display("FAIL auto_repeat_%0d got lat=%0d h=%0d b=%0b want lat=27 h=40 b=1",
                         r, lat, height, busy);
            end
        end
    endtask
`endif

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b0;
        start        = 1'b0;
        height_ready = 1'b0;
        set_sensors(8'd0, 8'd0, 8'd0, 8'd0);
        test_reset();
        test_basic();
        test_pairs();
        test_unstable();
        test_hold();
        test_mid_reset();
        test_back_to_back();
`ifdef AUTO_RESCAN_EN
        test_auto_rescan();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
